input_frame_buffer: RTL and testbench

Ping-pong capture buffer that sits directly upstream of Spectrum_Analyser. Collects a continuous stream of 16-bit samples into two banks of 2^ADDR_W words. When a bank is full, hands it to the analyser: pulses start_o, then serves the analyser's read addresses with registered data. Captures the next frame into the other bank while the analyser works.

---
 rtl/frame_buf_pkg.sv | 13 +
 rtl/frame_bank_ram.sv | 27 ++
 rtl/input_frame_buffer.sv | 103 ++++++++++
 tb/tb_input_frame_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// rtl/frame_buf_pkg.sv - shared widths, bank depth and FSM state type for the input frame buffer
package frame_buf_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH      = 1 << ADDR_W_DEF;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// rtl/frame_bank_ram.sv - two-bank simple dual-port RAM; address MSB selects the bank
module frame_bank_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array itself keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/input_frame_buffer.sv
// rtl/input_frame_buffer.sv - ping-pong capture buffer feeding the spectrum analyser; DROP_COUNT_EN adds drop_count_o
module input_frame_buffer
  import frame_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              start_o,
  input  logic              frame_done_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              overflow_o
`ifdef DROP_COUNT_EN
  ,
  output logic [15:0]       drop_count_o
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic              wr_sel;
  logic              rd_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;
  logic              drop;

  assign accept    = enable_i && sample_valid_i && (state == FILL);
  assign drop      = enable_i && sample_valid_i && (state == HOLD);
  assign wr_addr_o = wr_addr;

  frame_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (CLOCK_50),
    .rst   (rst),
    .we    (accept),
    .waddr ({wr_sel, wr_addr}),
    .wdata (sample_i),
    .raddr ({rd_sel, rd_addr_i}),
    .rdata (data_o)
  );

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state      <= FILL;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b1;
      wr_addr    <= '0;
      start_o    <= 1'b0;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      start_o <= 1'b0;
      if (drop) overflow_o <= 1'b1;
      case (state)
        FILL: begin
          if (accept && wr_addr == LAST_ADDR) begin
            // A release arriving with the last word lets us swap without stalling.
            if (!busy_o || frame_done_i) begin
              wr_sel  <= ~wr_sel;
              rd_sel  <= wr_sel;
              wr_addr <= '0;
              busy_o  <= 1'b1;
              start_o <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end else begin
            if (accept) wr_addr <= wr_addr + 1'b1;
            if (frame_done_i) busy_o <= 1'b0;
          end
        end
        HOLD: begin
          if (frame_done_i) begin
            wr_sel  <= ~wr_sel;
            rd_sel  <= wr_sel;
            wr_addr <= '0;
            start_o <= 1'b1;
            state   <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef DROP_COUNT_EN
  always_ff @(posedge CLOCK_50) begin
    if (rst)                                drop_count_o <= '0;
    else if (drop && drop_count_o != '1)    drop_count_o <= drop_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_input_frame_buffer.sv
// tb/tb_input_frame_buffer.sv - scoreboard bench for input_frame_buffer (start pulses and read data)
module tb_input_frame_buffer;

  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic [15:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic [9:0]  rd_addr_i = '0;
  logic [15:0] data_o;
  logic        start_o;
  logic        frame_done_i = 1'b0;
  logic        busy_o;
  logic [9:0]  wr_addr_o;
  logic        overflow_o;
`ifdef DROP_COUNT_EN
  logic [15:0] drop_count_o;
`endif

  input_frame_buffer dut (
    .CLOCK_50       (CLOCK_50),
    .rst            (rst),
    .enable_i       (enable_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .rd_addr_i      (rd_addr_i),
    .data_o         (data_o),
    .start_o        (start_o),
    .frame_done_i   (frame_done_i),
    .busy_o         (busy_o),
    .wr_addr_o      (wr_addr_o),
    .overflow_o     (overflow_o)
`ifdef DROP_COUNT_EN
    ,
    .drop_count_o   (drop_count_o)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_q[$];
  int   rd_q[$];
  logic rd_pend = 1'b0;
  logic rd_vld_d = 1'b0;

  always @(posedge CLOCK_50) begin
    cyc      <= cyc + 1;
    rd_vld_d <= rd_pend;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compares start pulses and read data against the queued expectations.
  always @(negedge CLOCK_50) begin
    if (start_o === 1'b1) begin
      total++;
      if (start_q.size() == 0) begin
        bad++;
        $display("FAIL start_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        int e;
        e = start_q.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL start_cycle: got %0d expected %0d", cyc, e);
        end
      end
    end
    if (rd_vld_d) begin
      int e;
      total++;
      e = (rd_q.size() > 0) ? rd_q.pop_front() : -1;
      if (data_o !== e[15:0] || e < 0) begin
        bad++;
        $display("FAIL read_data: got %0d expected %0d", data_o, e);
      end
    end
  end

  task automatic drive(input int v, input logic fd, input logic exp_start);
    @(negedge CLOCK_50);
    sample_i       = v[15:0];
    sample_valid_i = 1'b1;
    frame_done_i   = fd;
    if (exp_start) start_q.push_back(cyc + 1);
  endtask

  task automatic idle(input logic fd, input logic exp_start);
    @(negedge CLOCK_50);
    sample_valid_i = 1'b0;
    frame_done_i   = fd;
    if (exp_start) start_q.push_back(cyc + 1);
  endtask

  task automatic rd_check(input int a, input int e);
    @(negedge CLOCK_50);
    sample_valid_i = 1'b0;
    frame_done_i   = 1'b0;
    rd_addr_i      = a[9:0];
    rd_pend        = 1'b1;
    rd_q.push_back(e);
    @(negedge CLOCK_50);
    rd_pend = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_start"}, start_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_overflow"}, overflow_o, 0);
    chk({tag, "_wr_addr"}, wr_addr_o, 0);
    chk({tag, "_data"}, data_o, 0);
`ifdef DROP_COUNT_EN
    chk({tag, "_drop_count"}, drop_count_o, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLOCK_50);
    chk_reset_state("reset");
    rst      = 1'b0;
    enable_i = 1'b1;

    // 1: first frame, start one cycle after the 1024th sample
    for (int i = 0; i < 1024; i++) drive(i, 1'b0, i == 1023);
    idle(1'b0, 1'b0);
    chk("t1_busy", busy_o, 1);
    chk("t1_wr_addr", wr_addr_o, 0);
    chk("t1_overflow", overflow_o, 0);
    rd_check(0, 0);
    rd_check(511, 511);
    rd_check(1023, 1023);

    // 2: second frame fills with analyser still busy, then drops
    for (int i = 1024; i < 2048; i++) drive(i, 1'b0, 1'b0);
    for (int i = 2048; i < 2053; i++) drive(i, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("t2_wr_addr", wr_addr_o, 1023);
    chk("t2_overflow", overflow_o, 1);
    chk("t2_busy", busy_o, 1);
`ifdef DROP_COUNT_EN
    chk("t2_drop_count", drop_count_o, 5);
`endif

    // 3: release in HOLD swaps banks
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    chk("t3_busy", busy_o, 1);
    chk("t3_wr_addr", wr_addr_o, 0);
    rd_check(0, 1024);
    rd_check(511, 1535);
    rd_check(1023, 2047);

    // 4: release coincides with the last write of the next frame
    drive(3000, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("t3_first_write", wr_addr_o, 1);
    for (int i = 1; i < 1024; i++) drive(3000 + i, i == 1023, i == 1023);
    idle(1'b0, 1'b0);
    chk("t4_wr_addr", wr_addr_o, 0);
    chk("t4_busy", busy_o, 1);
    chk("t4_overflow", overflow_o, 1);
`ifdef DROP_COUNT_EN
    chk("t4_drop_count", drop_count_o, 5);
`endif
    rd_check(0, 3000);
    rd_check(1023, 4023);

    // 5: release in FILL, then pause capture mid-frame
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    chk("t5_busy_released", busy_o, 0);
    for (int i = 0; i < 300; i++) drive(5000 + i, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK_50);
      enable_i       = 1'b0;
      sample_valid_i = 1'b1;
      sample_i       = 16'hFFFF;
    end
    idle(1'b0, 1'b0);
    chk("t5_wr_addr_hold", wr_addr_o, 300);
    enable_i = 1'b1;
    for (int i = 300; i < 1024; i++) drive(5000 + i, 1'b0, i == 1023);
    idle(1'b0, 1'b0);
    chk("t5_busy", busy_o, 1);
    chk("t5_wr_addr", wr_addr_o, 0);
    rd_check(299, 5299);
    rd_check(300, 5300);
    rd_check(1023, 6023);

    // 6: reset mid-frame while busy
    for (int i = 0; i < 600; i++) drive(7000 + i, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("t6_wr_addr", wr_addr_o, 600);
    chk("t6_busy", busy_o, 1);
    rst = 1'b1;
    @(negedge CLOCK_50);
    chk_reset_state("t6_reset");
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) drive(8000 + i, 1'b0, i == 1023);
    idle(1'b0, 1'b0);
    chk("t6_busy_after", busy_o, 1);
    rd_check(0, 8000);
    rd_check(1023, 9023);

    repeat (4) idle(1'b0, 1'b0);
    chk("start_queue_empty", start_q.size(), 0);
    chk("read_queue_empty", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
